// File: rtl/as2650_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module  : as2650_bus_pkg
// Purpose : Shared types and constants for the AS2650 bus-side bridges.
// Rev     : 1.0  initial release
// ============================================================================
package as2650_bus_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ROM  = 2'd1,
        ST_EXT  = 2'd2,
        ST_ACK  = 2'd3
    } bus_state_e;

    typedef enum logic [1:0] {
        ACC_MEM_RD = 2'd0,
        ACC_MEM_WR = 2'd1,
        ACC_IO_RD  = 2'd2,
        ACC_IO_WR  = 2'd3
    } acc_type_e;

    localparam logic [7:0] c_exit_port_default = 8'hFE;

    function automatic acc_type_e encode_access(input logic mio, input logic wr);
        return mio ? (wr ? ACC_MEM_WR : ACC_MEM_RD) : (wr ? ACC_IO_WR : ACC_IO_RD);
    endfunction

    function automatic logic is_read(input acc_type_e acc);
        return (acc == ACC_MEM_RD) || (acc == ACC_IO_RD);
    endfunction

    function automatic logic is_io(input acc_type_e acc);
        return (acc == ACC_IO_RD) || (acc == ACC_IO_WR);
    endfunction

endpackage
`default_nettype wire

// File: rtl/bus_wait_timer.sv
`default_nettype none
// ============================================================================
// Module  : bus_wait_timer
// Purpose : Loadable 4-bit down-counter with a zero flag for bus wait states.
// Rev     : 1.0  initial release
// ============================================================================
module bus_wait_timer (
    input  logic       clk_i,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] load_val_i,
    input  logic       dec_i,
    output logic       done_o
);

    logic [3:0] count_q;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            count_q <= 4'd0;
        end else if (load_i) begin
            count_q <= load_val_i;
        end else if (dec_i && (count_q != 4'd0)) begin
            count_q <= count_q - 4'd1;
        end
    end

    assign done_o = (count_q == 4'd0);

endmodule
`default_nettype wire

// File: rtl/boot_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : boot_overlay_ctrl
// Purpose : Overlays boot ROM onto the low address window during boot and
//           forwards all other CPU accesses to external memory/IO.
// Rev     : 1.0  initial release
// ============================================================================
module boot_overlay_ctrl
    import as2650_bus_pkg::*;
#(
    parameter int         ROM_SIZE    = 256,
    parameter int         WAIT_STATES = 2,
    parameter logic [7:0] EXIT_PORT   = c_exit_port_default
) (
    input  logic        clk_i,
    input  logic        rst,
    input  logic [14:0] cpu_addr_i,
    input  logic        cpu_opreq_i,
    input  logic        cpu_mio_i,
    input  logic        cpu_wr_i,
    input  logic [7:0]  cpu_data_i,
    output logic [7:0]  cpu_data_o,
    output logic        cpu_opack_o,
    output logic [7:0]  last_addr_o,
    input  logic [7:0]  rom_data_i,
    output logic [14:0] mem_addr_o,
    output logic [7:0]  mem_data_o,
    input  logic [7:0]  mem_data_i,
    output logic        mem_re_o,
    output logic        mem_we_o,
    output logic        mem_io_o,
    output logic        boot_active_o
);

    localparam logic [14:0] c_rom_limit = 15'(ROM_SIZE);
    localparam logic [3:0]  c_wait_load = 4'(WAIT_STATES);

    bus_state_e  state_q;
    acc_type_e   acc_q;
    logic        req_lat_q;
    logic [14:0] addr_q;
    logic [7:0]  wdata_q;
    logic [7:0]  rdata_q;
    logic        opack_q;
    logic        re_q;
    logic        we_q;
    logic        io_q;
    logic        boot_q;

    logic w_rom_hit;
    logic w_exit_hit;
    logic w_tmr_load;
    logic w_tmr_dec;
    logic w_tmr_done;

    assign w_rom_hit  = boot_q && (acc_q == ACC_MEM_RD) && (addr_q < c_rom_limit);
    assign w_exit_hit = boot_q && (acc_q == ACC_IO_WR) && (addr_q[7:0] == EXIT_PORT);
    assign w_tmr_load = (state_q == ST_IDLE) && req_lat_q && !w_rom_hit;
    assign w_tmr_dec  = (state_q == ST_EXT) && !w_tmr_done;

    bus_wait_timer u_wait_timer (
        .clk_i      (clk_i),
        .rst        (rst),
        .load_i     (w_tmr_load),
        .load_val_i (c_wait_load),
        .dec_i      (w_tmr_dec),
        .done_o     (w_tmr_done)
    );

    // The request is latched on the sampling edge and classified one cycle
    // later, giving the external bus a full cycle of address setup.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            acc_q     <= ACC_MEM_RD;
            req_lat_q <= 1'b0;
            addr_q    <= 15'd0;
            wdata_q   <= 8'd0;
            rdata_q   <= 8'd0;
            opack_q   <= 1'b0;
            re_q      <= 1'b0;
            we_q      <= 1'b0;
            io_q      <= 1'b0;
            boot_q    <= 1'b1;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (req_lat_q) begin
                        req_lat_q <= 1'b0;
                        if (w_rom_hit) begin
                            state_q <= ST_ROM;
                        end else begin
                            state_q <= ST_EXT;
                            re_q    <= is_read(acc_q);
                            we_q    <= !is_read(acc_q);
                            io_q    <= is_io(acc_q);
                        end
                    end else if (cpu_opreq_i) begin
                        req_lat_q <= 1'b1;
                        addr_q    <= cpu_addr_i;
                        wdata_q   <= cpu_data_i;
                        acc_q     <= encode_access(cpu_mio_i, cpu_wr_i);
                    end
                end
                ST_ROM: begin
                    rdata_q <= rom_data_i;
                    opack_q <= 1'b1;
                    state_q <= ST_ACK;
                end
                ST_EXT: begin
                    if (w_tmr_done) begin
                        re_q    <= 1'b0;
                        we_q    <= 1'b0;
                        io_q    <= 1'b0;
                        opack_q <= 1'b1;
                        state_q <= ST_ACK;
                        if (is_read(acc_q)) begin
                            rdata_q <= mem_data_i;
                        end
                        if (w_exit_hit) begin
                            boot_q <= 1'b0;
                        end
                    end
                end
                ST_ACK: begin
                    // A request already withdrawn here yields a one-cycle pulse.
                    if (!cpu_opreq_i) begin
                        opack_q <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_data_o    = rdata_q;
    assign cpu_opack_o   = opack_q;
    assign last_addr_o   = addr_q[7:0];
    assign mem_addr_o    = addr_q;
    assign mem_data_o    = wdata_q;
    assign mem_re_o      = re_q;
    assign mem_we_o      = we_q;
    assign mem_io_o      = io_q;
    assign boot_active_o = boot_q;

endmodule
`default_nettype wire

// File: tb/tb_boot_overlay_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_boot_overlay_ctrl
// Purpose : Directed self-checking bench for boot_overlay_ctrl.
// Rev     : 1.0  initial release
// ============================================================================
module tb_boot_overlay_ctrl;

    logic        clk_i = 1'b0;
    logic        rst   = 1'b1;
    logic [14:0] cpu_addr = 15'd0;
    logic        cpu_opreq = 1'b0;
    logic        cpu_mio = 1'b0;
    logic        cpu_wr = 1'b0;
    logic [7:0]  cpu_wdata = 8'd0;
    logic [7:0]  cpu_rdata;
    logic        cpu_opack;
    logic [7:0]  last_addr;
    logic [7:0]  rom_data;
    logic [14:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic [7:0]  mem_rdata;
    logic        mem_re;
    logic        mem_we;
    logic        mem_io;
    logic        boot_active;

    int tests_run = 0;
    int tests_failed = 0;

    logic [7:0] ram [0:32767];

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] rom_model(input logic [7:0] a);
        case (a)
            8'h00:   return 8'hC0;
            8'h01:   return 8'h12;
            8'h02:   return 8'h1B;
            8'h05:   return 8'h00;
            8'hA3:   return 8'h43;
            default: return 8'hEE;
        endcase
    endfunction

    assign rom_data  = rom_model(last_addr);
    assign mem_rdata = mem_io ? 8'h9D : ram[mem_addr];

    always @(posedge clk_i) begin
        if (mem_we && !mem_io) ram[mem_addr] <= mem_wdata;
    end

    boot_overlay_ctrl #(
        .ROM_SIZE    (256),
        .WAIT_STATES (2),
        .EXIT_PORT   (8'hFE)
    ) dut (
        .clk_i         (clk_i),
        .rst           (rst),
        .cpu_addr_i    (cpu_addr),
        .cpu_opreq_i   (cpu_opreq),
        .cpu_mio_i     (cpu_mio),
        .cpu_wr_i      (cpu_wr),
        .cpu_data_i    (cpu_wdata),
        .cpu_data_o    (cpu_rdata),
        .cpu_opack_o   (cpu_opack),
        .last_addr_o   (last_addr),
        .rom_data_i    (rom_data),
        .mem_addr_o    (mem_addr),
        .mem_data_o    (mem_wdata),
        .mem_data_i    (mem_rdata),
        .mem_re_o      (mem_re),
        .mem_we_o      (mem_we),
        .mem_io_o      (mem_io),
        .boot_active_o (boot_active)
    );

    // Results of the most recent request issued by do_req.
    int          r_lat;
    int          r_strb;
    logic [7:0]  r_rdata;
    logic [7:0]  r_last;
    logic [14:0] r_saddr;
    logic [7:0]  r_swdata;
    logic        r_sio;
    logic        r_sboot;
    logic        r_boot_ack;
    logic        r_opack_after;

    // Called at a negedge; returns at a negedge with the FSM back in IDLE.
    task automatic do_req(input logic [14:0] a, input logic mio, input logic wr,
                          input logic [7:0] d);
        cpu_addr = a; cpu_mio = mio; cpu_wr = wr; cpu_wdata = d; cpu_opreq = 1'b1;
        r_lat = -1; r_strb = 0; r_rdata = 8'hXX; r_last = 8'hXX;
        r_saddr = 15'h7FFF; r_swdata = 8'hXX; r_sio = 1'bx; r_sboot = 1'bx;
        r_boot_ack = 1'bx;
        @(posedge clk_i);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            if (i == 0) r_last = last_addr;
            if (mem_re || mem_we) begin
                if (r_strb == 0) begin
                    r_saddr = mem_addr; r_swdata = mem_wdata; r_sio = mem_io;
                    r_sboot = boot_active;
                end
                r_strb++;
            end
            if (cpu_opack) begin
                r_lat = i; r_rdata = cpu_rdata; r_boot_ack = boot_active;
                break;
            end
            @(posedge clk_i);
        end
        cpu_opreq = 1'b0;
        @(posedge clk_i);
        @(negedge clk_i);
        r_opack_after = cpu_opack;
    endtask

    task automatic test_reset();
        @(negedge clk_i);
        rst = 1'b1;
        #1;
        tests_run++;
        if (cpu_opack !== 1'b0 || mem_re !== 1'b0 || mem_we !== 1'b0 || mem_io !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_strobes: opack=%b re=%b we=%b io=%b required all 0",
                     cpu_opack, mem_re, mem_we, mem_io);
        end
        tests_run++;
        if (boot_active !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_boot: got %b required 1", boot_active);
        end
        tests_run++;
        if (cpu_rdata !== 8'h00 || last_addr !== 8'h00 || mem_addr !== 15'h0000 || mem_wdata !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_regs: data=%h last=%h maddr=%h mdata=%h required 0",
                     cpu_rdata, last_addr, mem_addr, mem_wdata);
        end
        @(negedge clk_i);
        rst = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_rom_read();
        do_req(15'h0000, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (r_last !== 8'h00 || r_rdata !== 8'hC0 || r_lat !== 2) begin
            tests_failed++;
            $display("FAIL rom_0000: last=%h data=%h lat=%0d required 00 C0 2", r_last, r_rdata, r_lat);
        end
        tests_run++;
        if (r_strb !== 0 || r_opack_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL rom_0000_bus: strobes=%0d opack_after=%b required 0 0", r_strb, r_opack_after);
        end
        do_req(15'h00A3, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (r_last !== 8'hA3 || r_rdata !== 8'h43 || r_lat !== 2) begin
            tests_failed++;
            $display("FAIL rom_00A3: last=%h data=%h lat=%0d required A3 43 2", r_last, r_rdata, r_lat);
        end
    endtask

    task automatic test_ext_read();
        do_req(15'h0100, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (r_rdata !== 8'h3C || r_strb !== 3 || r_lat !== 4) begin
            tests_failed++;
            $display("FAIL ext_0100: data=%h strobes=%0d lat=%0d required 3C 3 4", r_rdata, r_strb, r_lat);
        end
        tests_run++;
        if (r_saddr !== 15'h0100 || r_sio !== 1'b0) begin
            tests_failed++;
            $display("FAIL ext_0100_addr: addr=%h io=%b required 0100 0", r_saddr, r_sio);
        end
        do_req(15'h0010, 1'b0, 1'b0, 8'h00);
        tests_run++;
        if (r_rdata !== 8'h9D || r_sio !== 1'b1 || r_strb !== 3 || r_lat !== 4) begin
            tests_failed++;
            $display("FAIL io_read: data=%h io=%b strobes=%0d lat=%0d required 9D 1 3 4",
                     r_rdata, r_sio, r_strb, r_lat);
        end
    endtask

    task automatic test_shadow_write();
        do_req(15'h0005, 1'b1, 1'b1, 8'h55);
        tests_run++;
        if (r_saddr !== 15'h0005 || r_swdata !== 8'h55 || r_strb !== 3 || r_lat !== 4) begin
            tests_failed++;
            $display("FAIL shadow_wr: addr=%h data=%h strobes=%0d lat=%0d required 0005 55 3 4",
                     r_saddr, r_swdata, r_strb, r_lat);
        end
        tests_run++;
        if (cpu_rdata !== 8'h9D || ram[15'h0005] !== 8'h55) begin
            tests_failed++;
            $display("FAIL shadow_wr_side: cpu_data=%h ram=%h required 9D 55", cpu_rdata, ram[15'h0005]);
        end
        do_req(15'h0005, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (r_rdata !== 8'h00 || r_strb !== 0 || r_lat !== 2) begin
            tests_failed++;
            $display("FAIL shadow_rd_rom: data=%h strobes=%0d lat=%0d required 00 0 2", r_rdata, r_strb, r_lat);
        end
    endtask

    task automatic test_boot_exit();
        do_req(15'h00FE, 1'b0, 1'b1, 8'h01);
        tests_run++;
        if (r_sboot !== 1'b1 || r_boot_ack !== 1'b0 || r_sio !== 1'b1 || r_strb !== 3) begin
            tests_failed++;
            $display("FAIL boot_exit: boot_strobe=%b boot_ack=%b io=%b strobes=%0d required 1 0 1 3",
                     r_sboot, r_boot_ack, r_sio, r_strb);
        end
        do_req(15'h0005, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (r_rdata !== 8'h55 || r_strb !== 3 || r_lat !== 4 || boot_active !== 1'b0) begin
            tests_failed++;
            $display("FAIL post_exit_rd: data=%h strobes=%0d lat=%0d boot=%b required 55 3 4 0",
                     r_rdata, r_strb, r_lat, boot_active);
        end
    endtask

    task automatic test_drop_mid();
        int strb;
        int pulses;
        strb = 0; pulses = 0;
        cpu_addr = 15'h0200; cpu_mio = 1'b1; cpu_wr = 1'b1; cpu_wdata = 8'h77; cpu_opreq = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        cpu_opreq = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk_i);
            @(negedge clk_i);
            if (mem_we) strb++;
            if (cpu_opack) pulses++;
        end
        tests_run++;
        if (strb !== 3 || pulses !== 1 || ram[15'h0200] !== 8'h77) begin
            tests_failed++;
            $display("FAIL drop_mid: strobes=%0d opack_cycles=%0d ram=%h required 3 1 77",
                     strb, pulses, ram[15'h0200]);
        end
        do_req(15'h0100, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (r_rdata !== 8'h3C || r_lat !== 4) begin
            tests_failed++;
            $display("FAIL drop_mid_next: data=%h lat=%0d required 3C 4", r_rdata, r_lat);
        end
    endtask

    task automatic test_reset_mid_ext();
        cpu_addr = 15'h0100; cpu_mio = 1'b1; cpu_wr = 1'b0; cpu_opreq = 1'b1;
        @(posedge clk_i);
        @(negedge clk_i);
        @(posedge clk_i);
        @(negedge clk_i);
        tests_run++;
        if (mem_re !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_pre: re=%b required 1", mem_re);
        end
        rst = 1'b1;
        cpu_opreq = 1'b0;
        #1;
        tests_run++;
        if (mem_re !== 1'b0 || cpu_opack !== 1'b0 || boot_active !== 1'b1) begin
            tests_failed++;
            $display("FAIL rst_mid_async: re=%b opack=%b boot=%b required 0 0 1", mem_re, cpu_opack, boot_active);
        end
        @(negedge clk_i);
        rst = 1'b0;
        @(negedge clk_i);
        do_req(15'h0002, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (r_rdata !== 8'h1B || r_lat !== 2 || r_strb !== 0) begin
            tests_failed++;
            $display("FAIL rst_mid_rom: data=%h lat=%0d strobes=%0d required 1B 2 0", r_rdata, r_lat, r_strb);
        end
    endtask

    task automatic test_back_to_back();
        do_req(15'h0001, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (r_rdata !== 8'h12 || r_lat !== 2) begin
            tests_failed++;
            $display("FAIL b2b_first: data=%h lat=%0d required 12 2", r_rdata, r_lat);
        end
        do_req(15'h00FF, 1'b1, 1'b0, 8'h00);
        tests_run++;
        if (r_rdata !== 8'hEE || r_last !== 8'hFF || r_lat !== 2) begin
            tests_failed++;
            $display("FAIL b2b_window_edge: data=%h last=%h lat=%0d required EE FF 2", r_rdata, r_last, r_lat);
        end
    endtask

    initial begin
        for (int i = 0; i < 32768; i++) ram[i] = 8'h00;
        ram[15'h0100] = 8'h3C;
        test_reset();
        test_rom_read();
        test_ext_read();
        test_shadow_write();
        test_boot_exit();
        test_drop_mid();
        test_reset_mid_ext();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/boot_overlay_ctrl.md
# boot_overlay_ctrl

Bus-side controller sitting between the AS2650 core's memory/IO request interface and `boot_rom`. It latches each CPU request address, drives the ROM's 8-bit `last_addr`, and overlays ROM read data onto the low address window while in boot mode. It forwards all other accesses (writes, I/O, out-of-window reads, and everything after boot exit) to external memory with programmable wait states. It completes every access with a four-phase OPREQ/OPACK handshake, and leaves boot mode on a write to a dedicated I/O port.

## Interface
Parameters:
- `ROM_SIZE`, default 256: overlay window size in bytes; window is `addr < ROM_SIZE`; max 256.
- `WAIT_STATES`, default 2: extra cycles an external access is held (0..15).
- `EXIT_PORT`, default 8'hFE: I/O port number whose write ends boot mode.

Ports:
- `clk_i` in 1: sole clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_addr_i` in 15: request address.
- `cpu_opreq_i` in 1: operation request, held until ack seen.
- `cpu_mio_i` in 1: 1 = memory, 0 = I/O.
- `cpu_wr_i` in 1: 1 = write.
- `cpu_data_i` in 8: write data.
- `cpu_data_o` out 8: registered read data.
- `cpu_opack_o` out 1: operation acknowledge.
- `last_addr_o` out 8: to `boot_rom.last_addr`.
- `rom_data_i` in 8: from `boot_rom.bus_out` (combinational from `last_addr_o`).
- `mem_addr_o` out 15, `mem_data_o` out 8, `mem_data_i` in 8: external bus.
- `mem_re_o`, `mem_we_o`, `mem_io_o` out 1: external read strobe, write strobe, I/O qualifier.
- `boot_active_o` out 1: overlay enabled.

## Operation
- FSM states: IDLE, ROM, EXT, ACK.
- IDLE:
  - On `cpu_opreq_i`=1, register address, type and write data.
  - Drive `last_addr_o`=addr[7:0] and `mem_addr_o`=addr.
  - Classify: ROM hit = `boot_active_o` & mio & !wr & addr<ROM_SIZE; go ROM if hit, else EXT.
- ROM: capture `rom_data_i` into `cpu_data_o`; go ACK.
- EXT:
  - Assert `mem_re_o` (read) or `mem_we_o` (write), with `mem_io_o`=!mio, for WAIT_STATES+1 cycles via down-counter.
  - On the last cycle, capture `mem_data_i` for reads; go ACK.
- ACK:
  - `cpu_opack_o`=1 while `cpu_opreq_i`=1; go IDLE when `cpu_opreq_i`=0.
  - If OPREQ already low on entry: one-cycle OPACK pulse, then IDLE.
  - A new request is accepted only from IDLE.
- Writes inside the window during boot go to external RAM (shadow copy); ROM is never written.
- Boot exit:
  - Trigger: I/O write with addr[7:0]==EXIT_PORT while boot active.
  - `boot_active_o` clears on the edge entering ACK.
  - The write is still forwarded externally.
  - Sticky until reset; all later reads of the window come from external memory.
- OPREQ dropped mid-ROM/EXT: access completes, including the external write; handled via the ACK pulse rule.
- Writes leave `cpu_data_o` unchanged.
- Reset, asynchronous, any state:
  - State IDLE; all strobes and OPACK 0 immediately.
  - `cpu_data_o`, `last_addr_o`, `mem_addr_o`, `mem_data_o` = 0.
  - `boot_active_o`=1, wait counter 0.

## Timing
- Edge E0 samples OPREQ in IDLE; address outputs valid after E0.
- ROM read: ACK entered at E2, so OPACK is high 2 cycles after the sampling edge.
- External access: OPACK high 2+WAIT_STATES cycles after E0; strobes high exactly WAIT_STATES+1 cycles.
- `cpu_data_o` is stable from the OPACK rise until the next read completes.
- OPACK falls on the first edge where OPREQ is sampled low in ACK. Minimum request-to-request spacing is 1 IDLE cycle.
- `mem_data_o` is stable for the entire strobe window.

## Structure
- Shared package `as2650_bus_pkg`: FSM state enum, default EXIT_PORT constant, access-type encoding {MEM_RD, MEM_WR, IO_RD, IO_WR}.
- Sub-module `bus_wait_timer`: loadable 4-bit down-counter with `done` flag, reused by other bus bridges.

## Test plan
- Reset, then memory read 0x0000 → `last_addr_o`=0x00, `cpu_data_o`=0xC0, OPACK 2 cycles after sample.
- Read 0x00A3 during boot → 0x43; read 0x0100 → external read, `mem_re_o` high 3 cycles (WAIT_STATES=2), OPACK at +4.
- Write 0x55 to 0x0005 during boot → `mem_we_o` with `mem_addr_o`=0x0005, `mem_data_o`=0x55; subsequent read of 0x0005 still returns ROM 0x00.
- I/O write to port 0xFE → `boot_active_o` falls at ACK entry; read 0x0005 now external, returns the RAM model's 0x55.
- OPREQ dropped one cycle after sampling an external write → write strobe still completes, single-cycle OPACK pulse, FSM back to IDLE.
- `rst` asserted mid-EXT → strobes drop asynchronously, `boot_active_o`=1, next read 0x0002 returns 0x1B.
